// File: rtl/trng_uart_tx_pkg.sv
// Shared definitions for the TRNG UART output stage: FSM encoding,
// default bit timing and synchronizer depth.
package trng_uart_defs;

    // Transmitter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Width of the per-bit cycle timer
    localparam int TIMER_W = 16;

    // Width of the exported occupancy count
    localparam int CNT_W = 4;

    // Number of flops in the RTS synchronizer chain
    localparam int SYNC_STAGES = 2;

    // Rounded clock cycles per UART bit
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Default for the 96 MHz PLL clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = clks_per_bit(96_000_000, 115_200);

    // FIFO depth in bytes for a given address width
    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/trng_byte_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// Head data is read combinationally so the transmitter can load it in
// the same cycle it pops; the array is tiny and maps to LUT RAM.
module trng_byte_fifo
    import trng_uart_defs::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                valid,
    input  logic [7:0]          dat,
    output logic                ready,
    input  logic                pop,
    output logic [7:0]          head,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  push;
    logic                  pop_ok;

    assign ready  = (count_reg < FULL_COUNT);
    assign push   = valid && ready;
    assign pop_ok = pop && (count_reg != '0);
    assign head   = mem[rd_ptr_reg];
    assign count  = count_reg;

    // Storage array: written on an accepted push, no reset needed
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= dat;
        end
    end

    // Pointers and occupancy; pointers wrap naturally modulo depth
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/trng_uart_tx.sv
// Buffered 8N1 UART transmitter with RTS flow control: the output stage
// of the TRNG datapath. Bytes are queued in a FIFO and sent LSB first
// only while the host holds RTS low.
module trng_uart_tx
    import trng_uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       i_dat,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_serial_rts_n,
    output logic             o_serial_data,
    output logic [CNT_W-1:0] o_dat_cnt
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    // RTS synchronizer
    logic [SYNC_STAGES-1:0] rts_sync_reg;
    logic                   rts_ok;

    // FIFO interface
    logic                   fifo_pop;
    logic [7:0]             fifo_head;
    logic [DEPTH_LOG2:0]    fifo_count;

    // Transmitter state
    tx_state_t              state_reg,  state_next;
    logic [TIMER_W-1:0]     timer_reg,  timer_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [7:0]             shift_reg,  shift_next;
    logic                   serial_reg, serial_next;
    logic                   timer_done;

    trng_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .valid (i_valid),
        .dat   (i_dat),
        .ready (o_ready),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign o_dat_cnt     = CNT_W'(fifo_count);
    assign o_serial_data = serial_reg;

    // Two-flop RTS synchronizer; resets to "host not ready"
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rts_sync_reg <= '1;
        end else begin
            rts_sync_reg <= {rts_sync_reg[SYNC_STAGES-2:0], i_serial_rts_n};
        end
    end

    assign rts_ok     = ~rts_sync_reg[SYNC_STAGES-1];
    assign timer_done = (timer_reg == TIMER_LAST);

    // FSM and datapath registers; the line is driven from a flop
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            serial_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            serial_reg  <= serial_next;
        end
    end

    // Next-state logic; serial_next is the line level for the next state
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        serial_next  = 1'b1;
        fifo_pop     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // RTS only gates the start of a new frame
                if ((fifo_count != '0) && rts_ok) begin
                    fifo_pop    = 1'b1;
                    shift_next  = fifo_head;
                    timer_next  = '0;
                    state_next  = ST_START;
                    serial_next = 1'b0;
                end
            end

            ST_START: begin
                serial_next = 1'b0;
                if (timer_done) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                    serial_next  = shift_reg[0];
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end

            ST_DATA: begin
                serial_next = shift_reg[0];
                if (timer_done) begin
                    timer_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next  = ST_STOP;
                        serial_next = 1'b1;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_idx_next = bit_idx_reg + 3'd1;
                        serial_next  = shift_reg[1];
                    end
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end

            ST_STOP: begin
                serial_next = 1'b1;
                if (timer_done) begin
                    timer_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/trng_uart_tx.md
Name: trng_uart_tx

Overview:
- Buffered 8N1 UART transmitter with hardware flow control. It is the output stage of the TRNG datapath.
- Accepts random bytes from the entropy post-processor through a valid/ready handshake and holds them in a small FIFO.
- Serializes bytes onto the FTDI serial line only while the host asserts RTS (active-low).
- Exports FIFO occupancy for the board-level LED display.

Parameters:
- CLKS_PER_BIT, 833, clock cycles per UART bit (96 MHz / 115200 baud); legal range 2..65535.
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 bytes (default 8); legal range 1..3.

Ports:
- CLK  input  1  system clock (96 MHz PLL output).
- RESET  input  1  synchronous, active-high reset.
- i_dat  input  8  byte to transmit.
- i_valid  input  1  i_dat valid this cycle.
- o_ready  output  1  FIFO can accept a byte this cycle.
- i_serial_rts_n  input  1  host RTS, active-low, asynchronous to CLK.
- o_serial_data  output  1  UART TX line; idle high.
- o_dat_cnt  output  4  FIFO occupancy, 0..2**DEPTH_LOG2.

Behaviour:
- Reset (RESET sampled high at a CLK edge):
  - FIFO empty, o_dat_cnt=0, o_ready=1 on the cycle after reset.
  - FSM=IDLE, o_serial_data=1, bit timer=0, both RTS sync flops=1 (treated as not-ready).
- Reset mid-frame aborts the frame immediately. The line returns high on the next cycle and buffered bytes are discarded.
- RTS: 2-flop synchronizer. rts_ok = (second flop == 0).
- Handshake and FIFO:
  - o_ready = (count < 2**DEPTH_LOG2), combinational from registered count.
  - Push occurs when i_valid && o_ready. With i_valid=1 and o_ready=0 the byte is dropped and the FIFO is unchanged. The producer must hold the byte.
  - Pop occurs on the IDLE->START transition only.
  - Push and pop in the same cycle leave count unchanged. This is legal when full: o_ready is already 0, so no push is accepted.
  - Order is strictly FIFO. Read/write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - o_dat_cnt is the registered count, zero-extended to 4 bits. It updates the cycle after a push or pop.
- FSM states and transitions:
  - IDLE: o_serial_data=1. If count!=0 && rts_ok: pop head into shift reg, timer:=0, go START.
  - START: o_serial_data=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
  - DATA: o_serial_data=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right. After bit 7, go STOP.
  - STOP: o_serial_data=1 for CLKS_PER_BIT cycles, then go IDLE.
- Output timing:
  - o_serial_data is registered. The first start-bit cycle appears the cycle after the IDLE decision.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 1 idle-high cycle between stop and the next start.
- Flow control:
  - RTS is checked only in IDLE.
  - RTS deasserting mid-frame does not truncate the frame. The current byte completes and the next does not start.
- Bit timer: counts 0..CLKS_PER_BIT-1, then wraps to 0 while advancing state. Width is 16 bits.

Decomposition:
- trng_uart_defs (shared package/include) holds:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Default CLKS_PER_BIT for 96 MHz/115200.
  - Synchronizer stage count (2).
- Sub-module trng_byte_fifo, containing:
  - Parameterized synchronous FIFO.
  - Push/pop, count, o_ready, head data.
  - Same CLK/RESET.
- The transmitter FSM, RTS synchronizer and shift register stay in trng_uart_tx.

Test Plan (CLKS_PER_BIT=4, DEPTH_LOG2=3):
1. Reset: hold RESET 3 cycles with i_valid=1 -> o_serial_data=1, o_dat_cnt=0, o_ready=1 after release, no push during reset.
2. Single byte: rts_n=0 (synced), push 0xA5 -> line stays high during the synchronizer and IDLE-decision cycles, then exactly 40 cycles of 0,1,0,1,0,0,1,0,1,1 (4 cycles each), then high. o_dat_cnt 1->0.
3. Fill: rts_n=1, push 0x00..0x09 every cycle -> first 8 accepted, o_ready=0 after the 8th, o_dat_cnt=8. Release rts_n=0 -> bytes 0x00..0x07 emitted in order, 1 idle cycle between frames.
4. RTS mid-frame: rts_n raised at cycle 12 of frame 1 with 3 bytes queued -> frame 1 completes all 40 cycles, line stays high, o_dat_cnt=2. Lowering rts_n resumes with byte 2.
5. Simultaneous push/pop: count=3, push on the IDLE->START cycle -> o_dat_cnt stays 3, pushed byte is sent last.
6. Reset mid-frame: RESET at cycle 20 of a frame with 4 queued -> line high next cycle, o_dat_cnt=0, no further frames after release until a new push.
